// File: rtl/gen_reg_file_if.sv
// Bus bundle for gen_reg_file: operation controls, read selects, read data and limit flags.
interface gen_reg_file_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 8
);
  localparam int SELW = $clog2(NREG);

  logic [WIDTH-1:0] I;
  logic [1:0]       FunSel;
  logic [NREG-1:0]  RSel;
  logic             Swap;
  logic [SELW-1:0]  O1Sel;
  logic [SELW-1:0]  O2Sel;
  logic             WrapClr;
  logic [WIDTH-1:0] O1;
  logic [WIDTH-1:0] O2;
  logic [NREG-1:0]  Lim;

  modport master (
    output I, FunSel, RSel, Swap, O1Sel, O2Sel, WrapClr,
    input  O1, O2, Lim
  );

  modport slave (
    input  I, FunSel, RSel, Swap, O1Sel, O2Sel, WrapClr,
    output O1, O2, Lim
  );
endinterface

// File: rtl/gen_reg_file.sv
// Register file with a swappable shadow bank, per-register clear/load/inc/dec,
// sticky limit flags and two registered read ports showing post-update data.
module gen_reg_file #(
  parameter int WIDTH    = 8,
  parameter int NREG     = 8,
  parameter bit SATURATE = 1'b0
) (
  input logic          clk,
  input logic          Reset_n,
  gen_reg_file_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_reg  [NREG];
  logic [WIDTH-1:0] s_reg  [NREG];
  logic [WIDTH-1:0] r_next [NREG];
  logic [NREG-1:0]  lim_reg;
  logic [NREG-1:0]  lim_next;
  logic [NREG-1:0]  lim_event;
  logic [WIDTH-1:0] o1_reg;
  logic [WIDTH-1:0] o2_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      logic [WIDTH-1:0] upd;
      logic             hit;

      // Swap overrides any per-register operation for the cycle.
      always_comb begin
        upd = r_reg[gi];
        hit = 1'b0;
        if (bus.Swap) begin
          upd = s_reg[gi];
        end else if (bus.RSel[gi]) begin
          case (bus.FunSel)
            2'b00: upd = '0;
            2'b01: upd = bus.I;
            2'b10: begin
              if (r_reg[gi] == '0) begin
                hit = 1'b1;
                upd = SATURATE ? '0 : '1;
              end else begin
                upd = r_reg[gi] - ONE;
              end
            end
            default: begin
              if (&r_reg[gi]) begin
                hit = 1'b1;
                upd = SATURATE ? '1 : '0;
              end else begin
                upd = r_reg[gi] + ONE;
              end
            end
          endcase
        end
      end

      assign r_next[gi]    = upd;
      assign lim_event[gi] = hit;
    end
  endgenerate

  // A limit event on the same edge as WrapClr wins, leaving the flag set.
  assign lim_next = lim_event | (lim_reg & ~{NREG{bus.WrapClr}});

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < NREG; k++) begin
        r_reg[k] <= '0;
        s_reg[k] <= '0;
      end
      lim_reg <= '0;
      o1_reg  <= '0;
      o2_reg  <= '0;
    end else begin
      for (int k = 0; k < NREG; k++) begin
        r_reg[k] <= r_next[k];
        if (bus.Swap) begin
          s_reg[k] <= r_reg[k];
        end
      end
      lim_reg <= lim_next;
      o1_reg  <= r_next[bus.O1Sel];
      o2_reg  <= r_next[bus.O2Sel];
    end
  end

  assign bus.O1  = o1_reg;
  assign bus.O2  = o2_reg;
  assign bus.Lim = lim_reg;

endmodule

// File: tb/tb_gen_reg_file.sv
// Bench for gen_reg_file: wrapping and saturating instances driven in lockstep,
// expected read data and flags queued per edge from a behavioural model.
module tb_gen_reg_file;

  localparam int W = 8;
  localparam int N = 8;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  gen_reg_file_if #(.WIDTH(W), .NREG(N)) b0 ();
  gen_reg_file_if #(.WIDTH(W), .NREG(N)) b1 ();

  gen_reg_file #(.WIDTH(W), .NREG(N), .SATURATE(1'b0)) dut0 (.clk(clk), .Reset_n(Reset_n), .bus(b0));
  gen_reg_file #(.WIDTH(W), .NREG(N), .SATURATE(1'b1)) dut1 (.clk(clk), .Reset_n(Reset_n), .bus(b1));

  typedef struct packed {
    logic [23:0] w0;
    logic [23:0] w1;
  } exp_t;

  exp_t exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] mr [2][8];
  logic [7:0] ms [2][8];
  logic [7:0] mlim [2];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mlim[m] = 8'h00;
      for (int k = 0; k < 8; k++) begin
        mr[m][k] = 8'h00;
        ms[m][k] = 8'h00;
      end
    end
  endtask

  // Behavioural model of one edge; m=0 wraps, m=1 saturates.
  task automatic model_edge(input logic [7:0] i, input logic [1:0] fs, input logic [7:0] rs,
                            input logic sw, input logic [2:0] a, input logic [2:0] b, input logic wc);
    exp_t e;
    logic [7:0] t;
    for (int m = 0; m < 2; m++) begin
      if (wc) mlim[m] = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (sw) begin
          t = mr[m][k];
          mr[m][k] = ms[m][k];
          ms[m][k] = t;
        end else if (rs[k]) begin
          case (fs)
            2'b00: mr[m][k] = 8'h00;
            2'b01: mr[m][k] = i;
            2'b10: begin
              if (mr[m][k] == 8'h00) begin
                mlim[m][k] = 1'b1;
                mr[m][k] = (m == 1) ? 8'h00 : 8'hFF;
              end else mr[m][k] = mr[m][k] - 8'd1;
            end
            default: begin
              if (mr[m][k] == 8'hFF) begin
                mlim[m][k] = 1'b1;
                mr[m][k] = (m == 1) ? 8'hFF : 8'h00;
              end else mr[m][k] = mr[m][k] + 8'd1;
            end
          endcase
        end
      end
    end
    e.w0 = {mr[0][a], mr[0][b], mlim[0]};
    e.w1 = {mr[1][a], mr[1][b], mlim[1]};
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [7:0] i, input logic [1:0] fs, input logic [7:0] rs,
                       input logic sw, input logic [2:0] a, input logic [2:0] b, input logic wc);
    @(negedge clk);
    b0.I = i;  b0.FunSel = fs; b0.RSel = rs; b0.Swap = sw; b0.O1Sel = a; b0.O2Sel = b; b0.WrapClr = wc;
    b1.I = i;  b1.FunSel = fs; b1.RSel = rs; b1.Swap = sw; b1.O1Sel = a; b1.O2Sel = b; b1.WrapClr = wc;
    model_edge(i, fs, rs, sw, a, b, wc);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    cycle_idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks += 2;
    if ({b0.O1, b0.O2, b0.Lim} !== 24'h0) begin
      n_fail++; $display("FAIL reset wrap: got %h expected %h", {b0.O1, b0.O2, b0.Lim}, 24'h0);
    end
    if ({b1.O1, b1.O2, b1.Lim} !== 24'h0) begin
      n_fail++; $display("FAIL reset sat: got %h expected %h", {b1.O1, b1.O2, b1.Lim}, 24'h0);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    $display("reset: outputs checked while held low, released");
  endtask

  task automatic cycle_idle_inputs();
    b0.I = '0; b0.FunSel = '0; b0.RSel = '0; b0.Swap = 1'b0; b0.O1Sel = '0; b0.O2Sel = '0; b0.WrapClr = 1'b0;
    b1.I = '0; b1.FunSel = '0; b1.RSel = '0; b1.Swap = 1'b0; b1.O1Sel = '0; b1.O2Sel = '0; b1.WrapClr = 1'b0;
  endtask

  // Each row: {I, FunSel, RSel, Swap, O1Sel, O2Sel, WrapClr}
  typedef struct packed {
    logic [7:0] i;
    logic [1:0] fs;
    logic [7:0] rs;
    logic       sw;
    logic [2:0] a;
    logic [2:0] b;
    logic       wc;
  } stim_t;

  task automatic run_table(input string name, input stim_t tbl[$]);
    exp_t e;
    for (int s = 0; s < tbl.size(); s++) begin
      cycle(tbl[s].i, tbl[s].fs, tbl[s].rs, tbl[s].sw, tbl[s].a, tbl[s].b, tbl[s].wc);
      e = exp_q.pop_front();
      n_checks += 2;
      if ({b0.O1, b0.O2, b0.Lim} !== e.w0) begin
        n_fail++; $display("FAIL %s[%0d] wrap {O1,O2,Lim}: got %h expected %h", name, s, {b0.O1, b0.O2, b0.Lim}, e.w0);
      end
      if ({b1.O1, b1.O2, b1.Lim} !== e.w1) begin
        n_fail++; $display("FAIL %s[%0d] sat {O1,O2,Lim}: got %h expected %h", name, s, {b1.O1, b1.O2, b1.Lim}, e.w1);
      end
      $display("%s[%0d]: I=%h F=%b R=%h sw=%b wc=%b -> wrap %h sat %h", name, s,
               tbl[s].i, tbl[s].fs, tbl[s].rs, tbl[s].sw, tbl[s].wc, {b0.O1, b0.O2, b0.Lim}, {b1.O1, b1.O2, b1.Lim});
    end
  endtask

  task automatic test_load();
    stim_t t[$];
    t.push_back('{8'h5A, 2'b01, 8'h81, 1'b0, 3'd0, 3'd7, 1'b0});
    for (int k = 1; k < 7; k += 2) t.push_back('{8'h00, 2'b01, 8'h00, 1'b0, 3'(k), 3'(k + 1), 1'b0});
    // Direct check of the documented load result on top of the model.
    cycle(8'h00, 2'b00, 8'h00, 1'b0, 3'd0, 3'd7, 1'b0);
    void'(exp_q.pop_front());
    run_table("load", t);
    n_checks++;
    if (b0.O1 !== 8'h00) begin
      n_fail++; $display("FAIL load scan R5 wrap: got %h expected %h", b0.O1, 8'h00);
    end
  endtask

  task automatic test_wrap();
    stim_t t[$];
    t.push_back('{8'hFF, 2'b01, 8'h04, 1'b0, 3'd2, 3'd2, 1'b0});
    t.push_back('{8'h00, 2'b11, 8'h04, 1'b0, 3'd2, 3'd2, 1'b0});
    t.push_back('{8'h00, 2'b11, 8'h00, 1'b0, 3'd2, 3'd0, 1'b1});
    run_table("wrap", t);
    n_checks++;
    if (b0.Lim !== 8'h00) begin
      n_fail++; $display("FAIL wrapclr Lim: got %h expected %h", b0.Lim, 8'h00);
    end
  endtask

  task automatic test_saturate();
    stim_t t[$];
    t.push_back('{8'h00, 2'b00, 8'h08, 1'b0, 3'd3, 3'd3, 1'b0});
    t.push_back('{8'h00, 2'b10, 8'h08, 1'b0, 3'd3, 3'd3, 1'b0});
    t.push_back('{8'h00, 2'b10, 8'h08, 1'b0, 3'd3, 3'd3, 1'b0});
    t.push_back('{8'h00, 2'b10, 8'h08, 1'b0, 3'd3, 3'd3, 1'b1});
    run_table("sat", t);
    n_checks += 2;
    if ({b1.O1, b1.Lim[3]} !== {8'h00, 1'b1}) begin
      n_fail++; $display("FAIL sat R3/Lim3: got %h expected %h", {b1.O1, b1.Lim[3]}, {8'h00, 1'b1});
    end
    if ({b0.O1, b0.Lim[3]} !== {8'hFD, 1'b0}) begin
      n_fail++; $display("FAIL wrap R3/Lim3: got %h expected %h", {b0.O1, b0.Lim[3]}, {8'hFD, 1'b0});
    end
  endtask

  task automatic test_swap();
    stim_t t[$];
    t.push_back('{8'h11, 2'b01, 8'h02, 1'b0, 3'd1, 3'd0, 1'b1});
    t.push_back('{8'h00, 2'b11, 8'h02, 1'b1, 3'd1, 3'd2, 1'b0});
    t.push_back('{8'h00, 2'b11, 8'h02, 1'b1, 3'd1, 3'd1, 1'b0});
    run_table("swap", t);
    n_checks++;
    if (b1.O1 !== 8'h11) begin
      n_fail++; $display("FAIL swap-back R1: got %h expected %h", b1.O1, 8'h11);
    end
  endtask

  task automatic test_back_to_back();
    stim_t t[$];
    t.push_back('{8'h33, 2'b01, 8'h10, 1'b0, 3'd4, 3'd4, 1'b0});
    t.push_back('{8'h34, 2'b01, 8'h10, 1'b0, 3'd4, 3'd5, 1'b0});
    for (int s = 0; s < 24; s++) begin
      t.push_back('{8'($urandom_range(0, 255)) | ((s % 4 == 0) ? 8'hFE : 8'h00),
                    2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                    1'($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 1'($urandom_range(0, 7) == 0)});
    end
    run_table("b2b", t);
  endtask

  task automatic test_reset_mid();
    stim_t t[$];
    for (int k = 0; k < 8; k++) t.push_back('{8'(8'h21 + k), 2'b01, 8'(1 << k), 1'b0, 3'(k), 3'(7 - k), 1'b0});
    t.push_back('{8'h00, 2'b00, 8'h00, 1'b1, 3'd0, 3'd1, 1'b0});
    t.push_back('{8'hC3, 2'b01, 8'hFF, 1'b0, 3'd2, 3'd3, 1'b0});
    t.push_back('{8'h00, 2'b11, 8'h00, 1'b0, 3'd2, 3'd3, 1'b0});
    run_table("preload", t);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    n_checks += 2;
    if ({b0.O1, b0.O2, b0.Lim} !== 24'h0) begin
      n_fail++; $display("FAIL midreset wrap: got %h expected %h", {b0.O1, b0.O2, b0.Lim}, 24'h0);
    end
    if ({b1.O1, b1.O2, b1.Lim} !== 24'h0) begin
      n_fail++; $display("FAIL midreset sat: got %h expected %h", {b1.O1, b1.O2, b1.Lim}, 24'h0);
    end
    // Swap held during reset must not move anything.
    b0.Swap = 1'b1; b1.Swap = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({b0.O1, b1.O1, b0.Lim, b1.Lim} !== 32'h0) begin
      n_fail++; $display("FAIL reset-swap: got %h expected %h", {b0.O1, b1.O1, b0.Lim, b1.Lim}, 32'h0);
    end
    @(negedge clk);
    Reset_n = 1'b1;
    $display("midreset: zeros observed before next edge");
    t.delete();
    t.push_back('{8'h00, 2'b11, 8'hFF, 1'b1, 3'd0, 3'd1, 1'b0});
    for (int k = 2; k < 8; k += 2) t.push_back('{8'h00, 2'b00, 8'h00, 1'b0, 3'(k), 3'(k + 1), 1'b0});
    run_table("postreset", t);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    cycle_idle_inputs();
    model_reset();
    test_reset();
    test_load();
    test_wrap();
    test_saturate();
    test_swap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gen_reg_file.md
GEN_REG_FILE -- requirements
Module: gen_reg_file

Interface
REQ-001 Parameter WIDTH, default 8, bit width of every register, input and output.
REQ-002 Parameter NREG, default 8, number of registers; power of two, 2..32.
REQ-003 Parameter SATURATE, default 0; 0 = inc/dec wrap modulo 2^WIDTH, 1 = inc/dec clamp at the limits.
REQ-004 Local SELW = log2(NREG), the width of the read-select ports.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 I  input  WIDTH  load data.
REQ-008 FunSel  input  2  00 clear, 01 load, 10 decrement, 11 increment.
REQ-009 RSel  input  NREG  one-hot-or-multi mask; bit k selects register k; all-zero = hold all.
REQ-010 Swap  input  1  exchange the main bank with the shadow bank.
REQ-011 O1Sel, O2Sel  input  SELW each  read-port register index.
REQ-012 WrapClr  input  1  clears all sticky limit flags.
REQ-013 O1, O2  output  WIDTH each  registered read data.
REQ-014 Lim  output  NREG  sticky per-register limit flags.

Function
REQ-015 The block SHALL hold NREG main registers R[k] and NREG shadow registers S[k], each WIDTH bits.
REQ-016 With Swap=0, each register R[k] with RSel[k]=1 SHALL update on the clock edge per FunSel; unselected registers SHALL hold.
REQ-017 Clear SHALL write 0; load SHALL write I; multiple selected registers SHALL all take the same operation in the same cycle.
REQ-018 Increment of all-ones SHALL give 0 when SATURATE=0 and all-ones when SATURATE=1.
REQ-019 Decrement of 0 SHALL give all-ones when SATURATE=0 and 0 when SATURATE=1.
REQ-020 Either limit event in REQ-018/REQ-019 SHALL set Lim[k] on that edge, in both modes.
REQ-021 Lim[k] SHALL stay set until a WrapClr edge; if WrapClr and a new limit event occur on the same edge, the flag SHALL end set.
REQ-022 With Swap=1, every R[k] and S[k] SHALL exchange contents on that edge.
REQ-023 With Swap=1, FunSel and RSel SHALL be ignored for that cycle; Lim SHALL not change except through WrapClr.
REQ-024 Shadow registers SHALL be reachable only through Swap.
REQ-025 O1 and O2 SHALL register, every edge, the post-update value of R[O1Sel] and R[O2Sel], so one-cycle latency covers the write performed on that same edge.
REQ-026 O1Sel equal to O2Sel SHALL give identical O1 and O2.
REQ-027 Arithmetic SHALL be unsigned and WIDTH bits wide; no carry-out port.

Reset
REQ-028 Reset_n low SHALL immediately force all R[k], S[k], O1, O2 and Lim to 0, independent of clk.
REQ-029 Reset during any operation, including Swap, SHALL take priority; the edge coincident with reset assertion has no effect.
REQ-030 The first edge after Reset_n rises SHALL operate normally; no warm-up cycles.

Verification
REQ-031 Reset, load I=0x5A with RSel=0x81, O1Sel=0, O2Sel=7 -> after one edge O1=O2=0x5A, other registers 0.
REQ-032 SATURATE=0: R2=0xFF, increment RSel=0x04 -> R2=0x00, Lim=0x04; then WrapClr -> Lim=0x00.
REQ-033 SATURATE=1: R3=0x00, decrement twice -> R3 stays 0x00, Lim[3]=1; on the same edge as a third decrement, WrapClr -> Lim[3] ends set.
REQ-034 R1=0x11, Swap -> R1=0x00, O1 (O1Sel=1)=0x00 after one edge; Swap again -> R1=0x11; FunSel=11 with RSel=0x02 during each Swap is ignored.
REQ-035 Load 0x33 into R4 with O1Sel=4 on the same edge -> O1=0x33 after that edge, no stale value.
REQ-036 Assert Reset_n low mid-cycle after loading all registers -> O1, O2, Lim and all registers read 0 before the next edge; a following Swap returns zeros.
